// File: rtl/mux_rr_sched_if.sv
// Request/grant bundle between the requesters and the round-robin mux scheduler.
// The requester side uses the master modport; the scheduler uses the slave modport.
interface mux_rr_sched_if #(
  parameter int N = 9,
  parameter int M = 4
);
  logic         en;
  logic [N-1:0] req;
  logic [M-1:0] sel;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic         gnt_new;

  modport master (
    output en, req,
    input  sel, gnt, gnt_valid, gnt_new
  );

  modport slave (
    input  en, req,
    output sel, gnt, gnt_valid, gnt_new
  );
endinterface

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler sharing one N:1 mux among N requesters.
// Each grant is held for up to HOLD cycles; sel and gnt are registered.
module mux_rr_sched #(
  parameter int N    = 9,
  parameter int M    = 4,
  parameter int HOLD = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_rr_sched_if.slave  bus
);
  localparam int HW = $clog2(HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state, state_nxt;
  logic [M-1:0]   ptr, ptr_nxt;
  logic [M-1:0]   sel_q, sel_nxt;
  logic [HW-1:0]  hold_cnt, hold_nxt;
  logic [N-1:0]   gnt_q, gnt_nxt;
  logic           valid_q, valid_nxt;
  logic           new_q, new_nxt;

  logic [M-1:0]   wrap_ptr;
  logic [M-1:0]   start;
  logic [M:0]     arb;
  logic           owner_req;
  logic           take;

  // Cyclic first-set search from start; returns {found, index}.
  function automatic logic [M:0] arbitrate(input logic [N-1:0] r, input logic [M-1:0] from);
    logic         found;
    logic [M-1:0] win;
    logic [N-1:0] rot;
    int           idx;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(from) + i;
      if (idx >= N) idx = idx - N;
      rot = r >> idx;
      if (!found && rot[0]) begin
        found = 1'b1;
        win   = M'(idx);
      end
    end
    return {found, win};
  endfunction

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel_q;
    hold_nxt  = hold_cnt;
    gnt_nxt   = gnt_q;
    valid_nxt = valid_q;
    new_nxt   = 1'b0;
    take      = 1'b0;

    wrap_ptr  = (sel_q == M'(N - 1)) ? '0 : sel_q + M'(1);
    start     = (state == GRANT) ? wrap_ptr : ptr;
    arb       = arbitrate(bus.req, start);
    owner_req = |(bus.req & gnt_q);

    case (state)
      IDLE: begin
        gnt_nxt   = '0;
        valid_nxt = 1'b0;
        take      = bus.en && arb[M];
      end
      GRANT: begin
        if (owner_req && hold_cnt != HW'(HOLD)) begin
          hold_nxt = hold_cnt + HW'(1);
        end else begin
          // Releasing owner becomes lowest priority, but may still win alone.
          ptr_nxt = wrap_ptr;
          if (bus.en && arb[M]) begin
            take = 1'b1;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            valid_nxt = 1'b0;
            hold_nxt  = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (take) begin
      state_nxt = GRANT;
      sel_nxt   = arb[M-1:0];
      gnt_nxt   = N'(1) << arb[M-1:0];
      valid_nxt = 1'b1;
      new_nxt   = 1'b1;
      hold_nxt  = HW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      sel_q    <= '0;
      hold_cnt <= '0;
      gnt_q    <= '0;
      valid_q  <= 1'b0;
      new_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      sel_q    <= sel_nxt;
      hold_cnt <= hold_nxt;
      gnt_q    <= gnt_nxt;
      valid_q  <= valid_nxt;
      new_q    <= new_nxt;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = valid_q;
  assign bus.gnt_new   = new_q;
endmodule

// File: tb/tb_mux_rr_sched.sv
// Self-checking bench for mux_rr_sched: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_mux_rr_sched;
  localparam int N    = 9;
  localparam int M    = 4;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst_n;

  int checkCount = 0;
  int passCount  = 0;

  mux_rr_sched_if #(.N(N), .M(M)) bus ();

  mux_rr_sched #(.N(N), .M(M), .HOLD(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic e);
    bus.req = r;
    bus.en  = e;
  endtask

  // Model: owner index (-1 when idle), cycles granted so far, next search start.
  int mOwner = -1;
  int mCnt   = 0;
  int mPtr   = 0;
  int mSel   = 0;
  int mNew   = 0;

  function automatic int winner(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      mOwner = -1; mCnt = 0; mPtr = 0; mSel = 0; mNew = 0;
    end else if (mOwner >= 0 && bus.req[mOwner] && mCnt < HOLD) begin
      mCnt++;
      mNew = 0;
    end else begin
      if (mOwner >= 0) mPtr = (mOwner + 1) % N;
      w = winner(bus.req, mPtr);
      if (bus.en && w >= 0) begin
        mOwner = w; mSel = w; mCnt = 1; mNew = 1;
      end else begin
        mOwner = -1; mCnt = 0; mNew = 0;
      end
    end
    #1;
    checkOutput("model_sel",   int'(bus.sel),       mSel);
    checkOutput("model_gnt",   int'(bus.gnt),       (mOwner < 0) ? 0 : (1 << mOwner));
    checkOutput("model_valid", int'(bus.gnt_valid), (mOwner >= 0) ? 1 : 0);
    checkOutput("model_new",   int'(bus.gnt_new),   mNew);
  end

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus('0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    rst_n = 1'b0;
    applyStimulus('0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("reset_gnt",   int'(bus.gnt),       0);
    checkOutput("reset_sel",   int'(bus.sel),       0);
    checkOutput("reset_valid", int'(bus.gnt_valid), 0);
    rst_n = 1'b1;

    // Single hog on requester 5: re-granted every HOLD cycles.
    applyStimulus(9'h020, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      checkOutput("hog_sel",   int'(bus.sel),       5);
      checkOutput("hog_valid", int'(bus.gnt_valid), 1);
      checkOutput("hog_new",   int'(bus.gnt_new),   (c % 4 == 1) ? 1 : 0);
    end
    checkOutput("hog_gnt", int'(bus.gnt), 'h020);

    // Asynchronous reset mid-grant.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("areset_gnt",   int'(bus.gnt),       0);
    checkOutput("areset_sel",   int'(bus.sel),       0);
    checkOutput("areset_valid", int'(bus.gnt_valid), 0);
    checkOutput("areset_new",   int'(bus.gnt_new),   0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full load: 0..8 then 0, each held HOLD cycles, no gaps.
    applyStimulus(9'h1FF, 1'b1);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      checkOutput("full_sel",   int'(bus.sel),       ((c - 1) / 4) % 9);
      checkOutput("full_valid", int'(bus.gnt_valid), 1);
    end

    // Early release of requester 2 after two cycles.
    doReset();
    applyStimulus(9'h044, 1'b1);
    @(negedge clk);
    checkOutput("early_sel_c1", int'(bus.sel), 2);
    @(negedge clk);
    checkOutput("early_sel_c2", int'(bus.sel), 2);
    applyStimulus(9'h040, 1'b1);
    @(negedge clk);
    checkOutput("early_sel_c3", int'(bus.sel),     6);
    checkOutput("early_new_c3", int'(bus.gnt_new), 1);

    // Wrap from 8 to 0, then back to 8.
    doReset();
    applyStimulus(9'h100, 1'b1);
    @(negedge clk);
    checkOutput("wrap_sel_c1", int'(bus.sel), 8);
    applyStimulus(9'h101, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("wrap_sel_c4", int'(bus.sel), 8);
    @(negedge clk);
    checkOutput("wrap_sel_c5", int'(bus.sel),     0);
    checkOutput("wrap_new_c5", int'(bus.gnt_new), 1);
    repeat (4) @(negedge clk);
    checkOutput("wrap_sel_c9", int'(bus.sel), 8);

    // Enable drop during a grant on 3.
    doReset();
    applyStimulus(9'h008, 1'b1);
    @(negedge clk);
    checkOutput("en_sel_c1", int'(bus.sel), 3);
    applyStimulus(9'h018, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("en_sel_c4",   int'(bus.sel),       3);
    checkOutput("en_valid_c4", int'(bus.gnt_valid), 1);
    @(negedge clk);
    checkOutput("en_gnt_c5",   int'(bus.gnt),       0);
    checkOutput("en_valid_c5", int'(bus.gnt_valid), 0);
    applyStimulus(9'h018, 1'b1);
    @(negedge clk);
    checkOutput("en_sel_c6", int'(bus.sel),     4);
    checkOutput("en_new_c6", int'(bus.gnt_new), 1);

    // Randomized traffic with occasional mid-cycle resets.
    r = '0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      if ($urandom_range(0, 1) == 0) begin
        r = N'($urandom_range(0, 511));
        if ($urandom_range(0, 2) == 0) r = r & N'($urandom_range(0, 511));
      end
      applyStimulus(r, $urandom_range(0, 5) != 0);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/mux_rr_sched.md
# mux_rr_sched

Round-robin scheduler that shares one `mux_n` N:1 multiplexer among N requesters. It arbitrates the request vector and holds each grant for a bounded burst. It drives the mux `select` bus directly as a registered binary index, with a matching one-hot grant. It sits beside `mux_n`: requester i owns mux input i, and `sel` connects to the mux select port.

## Interface
- `N`, 9, number of requesters and mux inputs (N ≥ 2).
- `M`, 4, select width; must equal the `m` of the driven `mux_n` (M ≥ clog2(N)).
- `HOLD`, 4, maximum consecutive cycles per grant (HOLD ≥ 1).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  scheduler enable; when low, no new grant is issued.
- `req`  in  N  per-requester request, level-sensitive.
- `sel`  out  M  registered binary index of the granted input; goes to the `mux_n` select.
- `gnt`  out  N  registered one-hot grant; all-zero when idle.
- `gnt_valid`  out  1  high while a grant is active.
- `gnt_new`  out  1  one-cycle pulse in the first cycle of every grant, including re-grants.

## Operation
- Internal state: `ptr` (M bits, next search start), `hold_cnt` (clog2(HOLD+1) bits), FSM state {IDLE, GRANT}.
- Arbitration function: the winner is the first index i with `req[i]`=1, searching cyclically from `ptr` to N-1, then 0 to `ptr`-1. Indices ≥ N never exist and are never selected.
- IDLE:
  - `gnt`=0, `gnt_valid`=0, `sel` holds its last value.
  - If `en`=1 and `req`≠0: register winner into `sel`, set `gnt`=onehot(winner), `gnt_valid`=1, `gnt_new`=1, `hold_cnt`=1, go to GRANT.
- GRANT, evaluated each edge:
  - Release condition: `req[sel]`=0, or `hold_cnt`=HOLD.
  - No release: `hold_cnt`++ and `gnt_new`=0.
  - On release:
    - `ptr` becomes `sel`+1, wrapping from N-1 to 0.
    - Arbitrate with the new `ptr`. This makes the current owner lowest priority, but it can still win if it is the only requester.
    - If `en`=1 and a winner exists: re-grant on the same edge (back-to-back, `gnt_valid` stays 1), `gnt_new`=1, `hold_cnt`=1.
    - Otherwise: go to IDLE with `gnt`=0 and `gnt_valid`=0.
- `en` dropping during GRANT does not cut the current grant; it only blocks the next one.
- Requests that appear or vanish on non-owner lines during GRANT have no effect until the next arbitration.

## Timing
- Reset (async, immediate): `sel`=0, `gnt`=0, `gnt_valid`=0, `gnt_new`=0, `ptr`=0, `hold_cnt`=0, state IDLE. Release of `rst_n` is treated as synchronous to `clk`.
- Latency: `req` sampled at edge k produces the grant visible after edge k (1 cycle). Mux output is valid combinationally in the same cycle as `gnt_valid`.
- Grant length: 1..HOLD cycles. With the owner holding `req`, the grant lasts exactly HOLD cycles.
- Owner drops `req` at edge k: the grant ends at edge k, with no extra cycle.
- Back-to-back switch: zero idle cycles between grants. `sel` and `gnt` change on the same edge.
- Simultaneous release and new requests: arbitration uses `req` sampled at the release edge.
- Reset mid-grant: outputs clear asynchronously. The first post-reset grant searches from index 0.
- HOLD=1: every grant lasts one cycle, and `gnt_new` is high in every active cycle.

## Test plan
- Reset: assert `rst_n`=0 mid-grant with `gnt`=0x020 → `gnt`, `sel`, `gnt_valid`, `gnt_new` go to 0 without waiting for a clock edge. After release, `req`=0x1FF gives `sel`=0 first.
- Single hog (N=9, HOLD=4): `req`=0x020 held for 12 cycles → `sel`=5 from cycle 1. `gnt_new` pulses at cycles 1, 5 and 9. `gnt_valid` is continuously 1.
- Full load: `req`=0x1FF held → `sel` sequence 0,1,…,8,0, each held 4 cycles, with no idle cycles.
- Early release: grant on 2, then `req[2]` drops after 2 granted cycles, with `req[6]`=1 → `sel`=6 on the next edge and `gnt_new`=1. Grant on 2 lasted exactly 2 cycles.
- Wrap and fairness: grant on 8 with `req`=0x101 at timeout → next `sel`=0, then 8. Requester 8 is not re-granted while 0 is waiting.
- Enable: `en`=0 during a grant on 3 with `req`=0x018 → grant on 3 completes its 4 cycles, then IDLE with `gnt`=0. Raising `en` gives `sel`=4 one cycle later.
